// File: rtl/sdram_arb.sv
// sdram_arb: arbiter and refresh scheduler in front of sdram_core.
// Shares the single SDRAM command engine between two clients and issues periodic
// auto-refresh. At most one of refresh, read or write is outstanding at the core.
//
// Optional feature macro: SDRAM_ARB_RR_EN
//   defined   -> round-robin between clients (the client not granted last wins a tie)
//   undefined -> fixed priority (client 0 beats client 1)
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cN_req_i/cN_we_i/cN_addr_i  client request, direction (1=write) and address
//   cN_gnt_o                    one-cycle pulse: column command accepted for client N
//   cN_done_o                   one-cycle pulse: core back to idle after client N's access
//   sdram_init_done_i           core initialisation finished
//   core_idle_i                 core work FSM is idle
//   sdram_ref_req_o/_ack_i      refresh handshake
//   sdram_wr_req_o/_ack_i       write handshake
//   sdram_rd_req_o/_ack_i       read handshake
//   sdram_addr_o                latched address of the current access
//   arb_owner_o                 client owning the current or last access
//   arb_busy_o                  arbiter not idle
//   ref_miss_o                  sticky: refresh interval elapsed with a refresh still pending
module sdram_arb #(
    parameter int unsigned REF_CYC = 1000,
    parameter int unsigned ADDR_W  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c0_req_i,
    input  logic              c0_we_i,
    input  logic [ADDR_W-1:0] c0_addr_i,
    input  logic              c1_req_i,
    input  logic              c1_we_i,
    input  logic [ADDR_W-1:0] c1_addr_i,
    output logic              c0_gnt_o,
    output logic              c1_gnt_o,
    output logic              c0_done_o,
    output logic              c1_done_o,
    input  logic              sdram_init_done_i,
    input  logic              core_idle_i,
    output logic              sdram_ref_req_o,
    input  logic              sdram_ref_ack_i,
    output logic              sdram_wr_req_o,
    output logic              sdram_rd_req_o,
    input  logic              sdram_wr_ack_i,
    input  logic              sdram_rd_ack_i,
    output logic [ADDR_W-1:0] sdram_addr_o,
    output logic              arb_owner_o,
    output logic              arb_busy_o,
    output logic              ref_miss_o
);

    localparam logic [15:0] RefReload = 16'(REF_CYC - 1);

    typedef enum logic [1:0] {StIdle, StRef, StAcc, StBusy} state_e;

    state_e            state_q, state_d;
    logic [15:0]       timer_q, timer_d;
    logic              ref_pend_q, ref_pend_d;
    logic              ref_miss_q, ref_miss_d;
    logic              is_ref_q, is_ref_d;
    logic              we_q, we_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ref_req_q, ref_req_d;
    logic              wr_req_q, wr_req_d;
    logic              rd_req_q, rd_req_d;
    logic              busy_q, busy_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic              expire;
    logic              ref_taken;
    logic              win;
`ifdef SDRAM_ARB_RR_EN
    logic              last_q, last_d;
`endif

    // Refresh timer: held at reload until the core is initialised.
    always_comb begin
        expire  = 1'b0;
        timer_d = timer_q;
        if (!sdram_init_done_i) begin
            timer_d = RefReload;
        end else if (timer_q == '0) begin
            timer_d = RefReload;
            expire  = 1'b1;
        end else begin
            timer_d = timer_q - 16'd1;
        end
    end

    // An expiry coinciding with the ack is a fresh request, not a miss.
    assign ref_taken  = (state_q == StRef) && sdram_ref_ack_i;
    assign ref_pend_d = expire | (ref_pend_q & ~ref_taken);
    assign ref_miss_d = ref_miss_q | (expire & ref_pend_q & ~ref_taken);

`ifdef SDRAM_ARB_RR_EN
    assign win = (c0_req_i && c1_req_i) ? ~last_q : c1_req_i;
`else
    assign win = ~c0_req_i;
`endif

    always_comb begin
        state_d  = state_q;
        is_ref_d = is_ref_q;
        we_d     = we_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        gnt_d    = 2'b00;
        done_d   = 2'b00;
`ifdef SDRAM_ARB_RR_EN
        last_d   = last_q;
`endif
        case (state_q)
            StIdle: begin
                if (sdram_init_done_i && core_idle_i) begin
                    if (ref_pend_q) begin
                        state_d  = StRef;
                        is_ref_d = 1'b1;
                    end else if (c0_req_i || c1_req_i) begin
                        state_d  = StAcc;
                        is_ref_d = 1'b0;
                        owner_d  = win;
                        we_d     = win ? c1_we_i : c0_we_i;
                        addr_d   = win ? c1_addr_i : c0_addr_i;
                    end
                end
            end
            StRef: begin
                if (sdram_ref_ack_i) begin
                    state_d = StBusy;
                end
            end
            StAcc: begin
                if ((we_q && sdram_wr_ack_i) || (!we_q && sdram_rd_ack_i)) begin
                    state_d        = StBusy;
                    gnt_d[owner_q] = 1'b1;
`ifdef SDRAM_ARB_RR_EN
                    last_d         = owner_q;
`endif
                end
            end
            StBusy: begin
                if (core_idle_i) begin
                    state_d = StIdle;
                    if (!is_ref_q) begin
                        done_d[owner_q] = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        ref_req_d = (state_d == StRef);
        wr_req_d  = (state_d == StAcc) && we_d;
        rd_req_d  = (state_d == StAcc) && !we_d;
        busy_d    = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            timer_q    <= RefReload;
            ref_pend_q <= 1'b0;
            ref_miss_q <= 1'b0;
            is_ref_q   <= 1'b0;
            we_q       <= 1'b0;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            ref_req_q  <= 1'b0;
            wr_req_q   <= 1'b0;
            rd_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
`ifdef SDRAM_ARB_RR_EN
            last_q     <= 1'b1; // client 0 wins the first tie
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ref_pend_q <= ref_pend_d;
            ref_miss_q <= ref_miss_d;
            is_ref_q   <= is_ref_d;
            we_q       <= we_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            ref_req_q  <= ref_req_d;
            wr_req_q   <= wr_req_d;
            rd_req_q   <= rd_req_d;
            busy_q     <= busy_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
`ifdef SDRAM_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    assign c0_gnt_o        = gnt_q[0];
    assign c1_gnt_o        = gnt_q[1];
    assign c0_done_o       = done_q[0];
    assign c1_done_o       = done_q[1];
    assign sdram_ref_req_o = ref_req_q;
    assign sdram_wr_req_o  = wr_req_q;
    assign sdram_rd_req_o  = rd_req_q;
    assign sdram_addr_o    = addr_q;
    assign arb_owner_o     = owner_q;
    assign arb_busy_o      = busy_q;
    assign ref_miss_o      = ref_miss_q;

endmodule

// File: tb/tb_sdram_arb.sv
// Self-checking bench for sdram_arb (REF_CYC=64 so refresh behaviour is reachable quickly).
// Expected grant order follows SDRAM_ARB_RR_EN when the bench is built with it.
module tb_sdram_arb;

    localparam int unsigned REF_CYC = 64;
    localparam int unsigned ADDR_W  = 24;

    logic              clk;
    logic              rst_n;
    logic              c0_req, c0_we, c1_req, c1_we;
    logic [ADDR_W-1:0] c0_addr, c1_addr;
    logic              c0_gnt, c1_gnt, c0_done, c1_done;
    logic              init_done, core_idle;
    logic              ref_req, ref_ack, wr_req, rd_req, wr_ack, rd_ack;
    logic [ADDR_W-1:0] sdram_addr;
    logic              arb_owner, arb_busy, ref_miss;

    sdram_arb #(.REF_CYC(REF_CYC), .ADDR_W(ADDR_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .c0_req_i          (c0_req),
        .c0_we_i           (c0_we),
        .c0_addr_i         (c0_addr),
        .c1_req_i          (c1_req),
        .c1_we_i           (c1_we),
        .c1_addr_i         (c1_addr),
        .c0_gnt_o          (c0_gnt),
        .c1_gnt_o          (c1_gnt),
        .c0_done_o         (c0_done),
        .c1_done_o         (c1_done),
        .sdram_init_done_i (init_done),
        .core_idle_i       (core_idle),
        .sdram_ref_req_o   (ref_req),
        .sdram_ref_ack_i   (ref_ack),
        .sdram_wr_req_o    (wr_req),
        .sdram_rd_req_o    (rd_req),
        .sdram_wr_ack_i    (wr_ack),
        .sdram_rd_ack_i    (rd_ack),
        .sdram_addr_o      (sdram_addr),
        .arb_owner_o       (arb_owner),
        .arb_busy_o        (arb_busy),
        .ref_miss_o        (ref_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {wr, rd, ref, gnt1, gnt0, done1, done0, busy, owner, miss, addr}
    logic [33:0] obs;
    assign obs = {wr_req, rd_req, ref_req, c1_gnt, c0_gnt, c1_done, c0_done,
                  arb_busy, arb_owner, ref_miss, sdram_addr};

    typedef struct {
        logic        c0r, c0w;
        logic [23:0] c0a;
        logic        c1r, c1w;
        logic [23:0] c1a;
        logic        idle, wack, rack;
        logic [33:0] want;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [33:0] e(input logic wr, input logic rd, input logic g0,
                                      input logic g1, input logic d0, input logic d1,
                                      input logic busy, input logic own, input logic [23:0] a);
        return {wr, rd, 1'b0, g1, g0, d1, d0, busy, own, 1'b0, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        c0_req = 0; c0_we = 0; c0_addr = '0;
        c1_req = 0; c1_we = 0; c1_addr = '0;
        ref_ack = 0; wr_ack = 0; rd_ack = 0;
        core_idle = 1'b1;
        init_done = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Responds as the core to one client access; returns the granted client (-1 if none).
    task automatic serve(input string name, output int who);
        int waited;
        waited = 0;
        who = -1;
        while (!(wr_req || rd_req) && waited < 30) begin
            step();
            waited++;
        end
        if (waited >= 30) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: no core request within 30 cycles", name);
            return;
        end
        if (wr_req) wr_ack = 1'b1;
        else rd_ack = 1'b1;
        step();
        wr_ack = 1'b0;
        rd_ack = 1'b0;
        if ({c1_gnt, c0_gnt} == 2'b01) who = 0;
        else if ({c1_gnt, c0_gnt} == 2'b10) who = 1;
        core_idle = 1'b0;
        step();
        step();
        core_idle = 1'b1;
        step();
        chk({name, " done"}, 64'({c1_done, c0_done}), (who == 1) ? 64'h2 : 64'h1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int who;
        int exp_order[4];
        int rise[3];
        int nrise;
        int bad;
        int phase;
        logic prev;

`ifdef SDRAM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif

        //            c0r c0w c0a         c1r c1w c1a         idle wack rack  expected
        vecs[0]  = '{1, 1, 24'h012345, 0, 0, 24'h0,      1, 0, 0, e(1,0,0,0,0,0,1,0,24'h012345)};
        vecs[1]  = '{1, 1, 24'h012345, 0, 0, 24'h0,      1, 0, 0, e(1,0,0,0,0,0,1,0,24'h012345)};
        vecs[2]  = '{1, 1, 24'h012345, 0, 0, 24'h0,      1, 1, 0, e(0,0,1,0,0,0,1,0,24'h012345)};
        vecs[3]  = '{0, 0, 24'h0,      0, 0, 24'h0,      0, 0, 0, e(0,0,0,0,0,0,1,0,24'h012345)};
        vecs[4]  = '{0, 0, 24'h0,      0, 0, 24'h0,      0, 0, 0, e(0,0,0,0,0,0,1,0,24'h012345)};
        vecs[5]  = '{0, 0, 24'h0,      0, 0, 24'h0,      1, 0, 0, e(0,0,0,0,1,0,0,0,24'h012345)};
        vecs[6]  = '{0, 0, 24'h0,      0, 0, 24'h0,      1, 0, 0, e(0,0,0,0,0,0,0,0,24'h012345)};
        vecs[7]  = '{0, 0, 24'h0,      1, 0, 24'hABCDEF, 1, 0, 0, e(0,1,0,0,0,0,1,1,24'hABCDEF)};
        vecs[8]  = '{0, 0, 24'h0,      1, 0, 24'hABCDEF, 1, 0, 1, e(0,0,0,1,0,0,1,1,24'hABCDEF)};
        vecs[9]  = '{0, 0, 24'h0,      0, 0, 24'h0,      1, 0, 0, e(0,0,0,0,0,1,0,1,24'hABCDEF)};
        vecs[10] = '{0, 0, 24'h0,      0, 0, 24'h0,      1, 0, 0, e(0,0,0,0,0,0,0,1,24'hABCDEF)};
        vecs[11] = '{1, 0, 24'h000777, 0, 0, 24'h0,      1, 0, 0, e(0,1,0,0,0,0,1,0,24'h000777)};
        vecs[12] = '{0, 0, 24'h0,      0, 0, 24'h0,      1, 0, 0, e(0,1,0,0,0,0,1,0,24'h000777)};
        vecs[13] = '{0, 0, 24'h0,      0, 0, 24'h0,      1, 0, 1, e(0,0,1,0,0,0,1,0,24'h000777)};
        vecs[14] = '{0, 0, 24'h0,      0, 0, 24'h0,      1, 0, 0, e(0,0,0,0,1,0,0,0,24'h000777)};
        vecs[15] = '{1, 1, 24'h0000AA, 0, 0, 24'h0,      0, 0, 0, e(0,0,0,0,0,0,0,0,24'h000777)};
        vecs[16] = '{1, 1, 24'h0000AA, 0, 0, 24'h0,      1, 0, 0, e(1,0,0,0,0,0,1,0,24'h0000AA)};
        vecs[17] = '{1, 1, 24'h0000AA, 0, 0, 24'h0,      1, 0, 1, e(1,0,0,0,0,0,1,0,24'h0000AA)};
        vecs[18] = '{1, 1, 24'h0000AA, 0, 0, 24'h0,      1, 1, 0, e(0,0,1,0,0,0,1,0,24'h0000AA)};
        vecs[19] = '{0, 0, 24'h0,      0, 0, 24'h0,      1, 0, 0, e(0,0,0,0,1,0,0,0,24'h0000AA)};

        // Reset state, then nothing issued before init completes.
        do_reset();
        chk("reset outputs", 64'(obs), 64'h0);
        c0_req = 1'b1;
        c0_we  = 1'b1;
        step(); step(); step();
        chk("no issue before init", 64'(obs), 64'h0);
        c0_req = 1'b0;
        init_done = 1'b1;

        // Table-driven single accesses.
        for (int i = 0; i < NV; i++) begin
            c0_req = vecs[i].c0r; c0_we = vecs[i].c0w; c0_addr = vecs[i].c0a;
            c1_req = vecs[i].c1r; c1_we = vecs[i].c1w; c1_addr = vecs[i].c1a;
            core_idle = vecs[i].idle; wr_ack = vecs[i].wack; rd_ack = vecs[i].rack;
            step();
            chk($sformatf("vec%0d", i), 64'(obs), 64'(vecs[i].want));
        end

        // Both clients hold continuous reads.
        do_reset();
        init_done = 1'b1;
        c0_req = 1'b1; c0_addr = 24'h000100;
        c1_req = 1'b1; c1_addr = 24'h000200;
        for (int i = 0; i < 4; i++) begin
            serve($sformatf("arb%0d", i), who);
            chk($sformatf("arb%0d winner", i), 64'(who), 64'(exp_order[i]));
        end
        c0_req = 1'b0;
        c1_req = 1'b0;

        // Periodic refresh while idle.
        do_reset();
        init_done = 1'b1;
        nrise = 0; bad = 0; phase = 0; prev = 1'b0;
        rise = '{0, 0, 0};
        for (int k = 1; k <= 210; k++) begin
            step();
            if (ref_req && !prev) begin
                if (nrise < 3) rise[nrise] = k;
                nrise++;
            end
            prev = ref_req;
            if (c0_gnt || c1_gnt || c0_done || c1_done) bad++;
            if (ref_req && phase == 0) begin
                ref_ack = 1'b1; phase = 1;
            end else if (phase == 1) begin
                ref_ack = 1'b0; core_idle = 1'b0; phase = 2;
            end else if (phase == 2) begin
                core_idle = 1'b1; phase = 0;
            end
        end
        chk("refresh count", 64'(nrise), 64'd3);
        chk("refresh first", 64'(rise[0]), 64'd65);
        chk("refresh period1", 64'(rise[1] - rise[0]), 64'(REF_CYC));
        chk("refresh period2", 64'(rise[2] - rise[1]), 64'(REF_CYC));
        chk("refresh no client pulses", 64'(bad), 64'd0);
        chk("refresh no miss", 64'(ref_miss), 64'd0);

        // Refresh expiring mid-access is served before the waiting client.
        do_reset();
        init_done = 1'b1;
        for (int k = 0; k < 50; k++) step();
        c0_req = 1'b1; c0_we = 1'b1; c0_addr = 24'h00C0C0;
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = 24'h00C1C1;
        step();
        chk("mid c0 wr_req", 64'({wr_req, rd_req, arb_owner}), 64'b100);
        for (int k = 0; k < 20; k++) step();
        wr_ack = 1'b1;
        step();
        chk("mid c0 gnt", 64'({c1_gnt, c0_gnt}), 64'b01);
        wr_ack = 1'b0; c0_req = 1'b0; core_idle = 1'b0;
        step();
        core_idle = 1'b1;
        step();
        chk("mid c0 done", 64'({c1_done, c0_done, arb_busy}), 64'b010);
        step();
        chk("mid refresh first", 64'({ref_req, rd_req, wr_req}), 64'b100);
        ref_ack = 1'b1;
        step();
        ref_ack = 1'b0;
        step();
        chk("mid refresh no done", 64'({c1_done, c0_done, arb_busy}), 64'b000);
        step();
        chk("mid c1 after refresh", 64'({rd_req, arb_owner, sdram_addr}), {38'h0, 1'b1, 1'b1, 24'h00C1C1});
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0; c1_req = 1'b0;
        step();

        // Refresh never acknowledged: ref_miss sets on the second expiry and sticks.
        do_reset();
        init_done = 1'b1;
        for (int k = 0; k < 100; k++) step();
        chk("miss pre", 64'({ref_req, ref_miss}), 64'b10);
        for (int k = 0; k < 30; k++) step();
        chk("miss set", 64'({ref_req, ref_miss}), 64'b11);
        for (int k = 0; k < 70; k++) step();
        chk("miss held", 64'(ref_miss), 64'd1);
        ref_ack = 1'b1;
        step();
        ref_ack = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("miss sticky after ack", 64'(ref_miss), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("miss cleared by reset", 64'(obs), 64'h0);

        // Reset asserted in the middle of an access.
        do_reset();
        init_done = 1'b1;
        c0_req = 1'b1; c0_we = 1'b1; c0_addr = 24'h00BEEF;
        step();
        chk("acc before reset", 64'({wr_req, arb_busy, sdram_addr}), {38'h0, 1'b1, 1'b1, 24'h00BEEF});
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset immediate", 64'(obs), 64'h0);
        step();
        chk("reset next cycle", 64'(obs), 64'h0);
        c0_req = 1'b0;
        rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
